// File: rtl/piso_shift_reg_if.sv
// Load/serial bundle of the parallel-in, serial-out shift register.
//
// Handshake rules:
// - A word moves on a rising edge where Load_Valid and Load_Ready are both 1.
//   Upstream holds D and Load_Valid steady until that edge.
// - A serial bit is consumed on a rising edge where Serial_Valid and
//   Shift_En are both 1. Otherwise Serial_Out, Done and Bit_Cnt hold.
// - Load_Ready may depend on Shift_En in the same cycle. This covers the last
//   bit of a word, where the next word can only enter as the last bit leaves.
//   No other output depends combinationally on an input.
interface piso_shift_reg_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] D;
    logic             Load_Valid;
    logic             Load_Ready;
    logic             Shift_En;
    logic             Serial_Out;
    logic             Serial_Valid;
    logic             Done;
    logic [CW-1:0]    Bit_Cnt;
    logic             State_Dbg;     // 0 = IDLE, 1 = SHIFT

    modport master (
        output D, Load_Valid, Shift_En,
        input  Load_Ready, Serial_Out, Serial_Valid, Done, Bit_Cnt, State_Dbg
    );

    modport slave (
        input  D, Load_Valid, Shift_En,
        output Load_Ready, Serial_Out, Serial_Valid, Done, Bit_Cnt, State_Dbg
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register with a valid/ready load side.
// It emits one bit per enabled cycle. A word can replace the last bit of the
// previous word on the same edge, so back-to-back words leave no gap.
module piso_shift_reg #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              Clk,
    input  logic              Rst,
    piso_shift_reg_if.slave   bus
);
    localparam int CW      = $clog2(WIDTH);
    localparam int OUT_IDX = LSB_FIRST ? 0 : WIDTH - 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_q,  sreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;

    logic is_last;
    logic load_ready;

    // The bit now on Serial_Out is the final bit of the current word.
    assign is_last = (state_q == SHIFT) && (cnt_q == LAST_CNT);

    // In IDLE a word is always welcome. During the last bit a word is welcome
    // only if that bit leaves on the same edge.
    always_comb begin
        load_ready = 1'b0;
        if (state_q == IDLE) begin
            load_ready = 1'b1;
        end else if (is_last) begin
            load_ready = bus.Shift_En;
        end
    end

    // Next-state logic: load, shift toward the output end, stall, or retire.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.Load_Valid) begin
                    state_d = SHIFT;
                    sreg_d  = bus.D;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (bus.Shift_En) begin
                    if (is_last) begin
                        cnt_d = '0;
                        if (bus.Load_Valid) begin
                            sreg_d = bus.D;
                        end else begin
                            state_d = IDLE;
                            sreg_d  = '0;
                        end
                    end else begin
                        // Zero-fill behind the bit that just left.
                        sreg_d = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
                        cnt_d  = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State, data and bit-counter registers. Reset discards any word in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.Load_Ready   = load_ready;
    assign bus.Serial_Valid = (state_q == SHIFT);
    assign bus.Serial_Out   = (state_q == SHIFT) & sreg_q[OUT_IDX];
    assign bus.Done         = is_last;
    assign bus.Bit_Cnt      = cnt_q;
    assign bus.State_Dbg    = (state_q == SHIFT);

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg with WIDTH=4. It uses one LSB-first instance and
// one MSB-first instance. Each queue entry holds the expected {Done, Bit_Cnt,
// Serial_Out} of one consumed bit. The bit sequences are written out by hand.
module tb_piso_shift_reg;
    logic clk;
    logic rst;

    piso_shift_reg_if #(.WIDTH(4)) bus_a ();
    piso_shift_reg_if #(.WIDTH(4)) bus_b ();

    piso_shift_reg #(.WIDTH(4), .LSB_FIRST(1'b1)) dut_a (
        .Clk (clk),
        .Rst (rst),
        .bus (bus_a.slave)
    );

    piso_shift_reg #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_b (
        .Clk (clk),
        .Rst (rst),
        .bus (bus_b.slave)
    );

    // Clock block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    logic [3:0] exp_q_a[$];
    logic [3:0] exp_q_b[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push four expected bits in transmit order. seq[3] is sent first.
    task automatic push_seq(input bit use_b, input logic [3:0] seq);
        logic [3:0] e;
        for (int i = 0; i < 4; i++) begin
            e = {(i == 3), 2'(i), seq[3-i]};
            if (use_b) exp_q_b.push_back(e);
            else       exp_q_a.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare every consumed serial bit against the head of the matching queue.
    task automatic monitor();
        logic [3:0] e;
        if (!rst && bus_a.Serial_Valid && bus_a.Shift_En) begin
            if (exp_q_a.size() == 0) begin
                check("a_unexpected_bit", 8'(bus_a.Bit_Cnt), 8'hFF);
            end else begin
                e = exp_q_a.pop_front();
                check("a_serial_out", 8'(bus_a.Serial_Out), 8'(e[0]));
                check("a_bit_cnt",    8'(bus_a.Bit_Cnt),    8'(e[2:1]));
                check("a_done",       8'(bus_a.Done),       8'(e[3]));
            end
        end
        if (!rst && bus_b.Serial_Valid && bus_b.Shift_En) begin
            if (exp_q_b.size() == 0) begin
                check("b_unexpected_bit", 8'(bus_b.Bit_Cnt), 8'hFF);
            end else begin
                e = exp_q_b.pop_front();
                check("b_serial_out", 8'(bus_b.Serial_Out), 8'(e[0]));
                check("b_bit_cnt",    8'(bus_b.Bit_Cnt),    8'(e[2:1]));
                check("b_done",       8'(bus_b.Done),       8'(e[3]));
            end
        end
    endtask

    task automatic check_idle_a(input string name);
        check({name, "_serial_valid"}, 8'(bus_a.Serial_Valid), 8'h0);
        check({name, "_load_ready"},   8'(bus_a.Load_Ready),   8'h1);
        check({name, "_bit_cnt"},      8'(bus_a.Bit_Cnt),      8'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_a.D = '0; bus_a.Load_Valid = 1'b0; bus_a.Shift_En = 1'b1;
        bus_b.D = '0; bus_b.Load_Valid = 1'b0; bus_b.Shift_En = 1'b1;

        fork
            forever begin
                @(negedge clk);
                monitor();
            end
        join_none

        // Reset state
        step();
        step();
        check("rst_serial_valid", 8'(bus_a.Serial_Valid), 8'h0);
        check("rst_serial_out",   8'(bus_a.Serial_Out),   8'h0);
        check("rst_done",         8'(bus_a.Done),         8'h0);
        check("rst_load_ready",   8'(bus_a.Load_Ready),   8'h1);
        check("rst_bit_cnt",      8'(bus_a.Bit_Cnt),      8'h0);
        rst = 1'b0;
        step();

        // LSB-first 4'hB gives 1,1,0,1.
        bus_a.D = 4'hB; bus_a.Load_Valid = 1'b1;
        push_seq(1'b0, 4'b1101);
        step();
        bus_a.Load_Valid = 1'b0;
        bus_a.D = 4'h0;   // D changes after capture must not matter
        repeat (4) step();
        check_idle_a("t1_after");

        // MSB-first 4'hB gives 1,0,1,1.
        bus_b.D = 4'hB; bus_b.Load_Valid = 1'b1;
        push_seq(1'b1, 4'b1011);
        step();
        bus_b.Load_Valid = 1'b0;
        repeat (4) step();
        check("t2_b_serial_valid", 8'(bus_b.Serial_Valid), 8'h0);
        check("t2_b_load_ready",   8'(bus_b.Load_Ready),   8'h1);

        // Back-to-back 4'h5 then 4'hA gives 1,0,1,0 and then 0,1,0,1.
        bus_a.D = 4'h5; bus_a.Load_Valid = 1'b1;
        push_seq(1'b0, 4'b1010);
        step();
        bus_a.Load_Valid = 1'b0;
        check("t3_not_ready_mid", 8'(bus_a.Load_Ready), 8'h0);
        repeat (3) step();
        bus_a.D = 4'hA; bus_a.Load_Valid = 1'b1;
        push_seq(1'b0, 4'b0101);
        check("t3_ready_last", 8'(bus_a.Load_Ready), 8'h1);
        step();
        bus_a.Load_Valid = 1'b0;
        check("t3_wrap_valid", 8'(bus_a.Serial_Valid), 8'h1);
        check("t3_wrap_cnt",   8'(bus_a.Bit_Cnt),      8'h0);
        repeat (4) step();
        check_idle_a("t3_after");

        // 4'hC with a 3-cycle stall on bit 1 gives 0,[0 held],1,1.
        bus_a.D = 4'hC; bus_a.Load_Valid = 1'b1;
        push_seq(1'b0, 4'b0011);
        step();
        bus_a.Load_Valid = 1'b0;
        step();
        bus_a.Shift_En = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_a.D = 4'hF;
            bus_a.Load_Valid = (i == 1);
            #2;
            check("t4_stall_cnt",   8'(bus_a.Bit_Cnt),    8'h1);
            check("t4_stall_out",   8'(bus_a.Serial_Out), 8'h0);
            check("t4_stall_ready", 8'(bus_a.Load_Ready), 8'h0);
            step();
        end
        bus_a.Load_Valid = 1'b0;
        bus_a.Shift_En = 1'b1;
        check("t4_resume_cnt", 8'(bus_a.Bit_Cnt), 8'h1);
        repeat (3) step();
        check_idle_a("t4_after");

        // Last-bit stall: a pending load waits for Shift_En.
        bus_a.D = 4'hB; bus_a.Load_Valid = 1'b1;
        push_seq(1'b0, 4'b1101);
        step();
        bus_a.Load_Valid = 1'b0;
        repeat (3) step();
        bus_a.Shift_En = 1'b0;
        bus_a.D = 4'h6; bus_a.Load_Valid = 1'b1;
        #1;
        check("t5_stall_ready", 8'(bus_a.Load_Ready), 8'h0);
        step();
        check("t5_hold_cnt",  8'(bus_a.Bit_Cnt), 8'h3);
        check("t5_hold_done", 8'(bus_a.Done),    8'h1);
        bus_a.Shift_En = 1'b1;
        push_seq(1'b0, 4'b0110);
        #1;
        check("t5_go_ready", 8'(bus_a.Load_Ready), 8'h1);
        step();
        bus_a.Load_Valid = 1'b0;
        check("t5_loaded_cnt", 8'(bus_a.Bit_Cnt), 8'h0);
        repeat (4) step();
        check_idle_a("t5_after");

        // Asynchronous reset mid-word, then a fresh 4'h6 gives 0,1,1,0.
        bus_a.D = 4'h5; bus_a.Load_Valid = 1'b1;
        push_seq(1'b0, 4'b1010);
        step();
        bus_a.Load_Valid = 1'b0;
        repeat (2) step();
        check("t6_pre_cnt", 8'(bus_a.Bit_Cnt), 8'h2);
        #1;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 8'(bus_a.Serial_Valid), 8'h0);
        check("t6_rst_out",   8'(bus_a.Serial_Out),   8'h0);
        check("t6_rst_done",  8'(bus_a.Done),         8'h0);
        check("t6_rst_cnt",   8'(bus_a.Bit_Cnt),      8'h0);
        check("t6_rst_ready", 8'(bus_a.Load_Ready),   8'h1);
        exp_q_a.delete();
        step();
        rst = 1'b0;
        step();
        bus_a.D = 4'h6; bus_a.Load_Valid = 1'b1;
        push_seq(1'b0, 4'b0110);
        step();
        bus_a.Load_Valid = 1'b0;
        repeat (4) step();
        check_idle_a("t6_after");

        repeat (2) step();
        check("a_queue_drained", 8'(exp_q_a.size()), 8'h0);
        check("b_queue_drained", 8'(exp_q_b.size()), 8'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
